// File: rtl/psdifir_pkg.sv
// Shared constants and state encoding for the psdifir FIR control path.
// No logic here; widths and default latencies only.
package psdifir_pkg;

  localparam int SAMPLE_W    = 18;
  localparam int ADDR_W      = 14;
  localparam int NTAPS_DEF   = 16384;
  localparam int RD_LAT_DEF  = 1;
  localparam int MAC_LAT_DEF = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_LATCH = 3'd4,
    ST_DONE  = 3'd5
  } state_t;

endpackage

// File: rtl/psdifir_delay_line.sv
// Fixed-depth shift register used to align issue/first with RAM read latency.
// Latency DEPTH clocks; no backpressure, shifts every clock.
module psdifir_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_clr_n,
  input  logic [WIDTH-1:0] i_dat,
  output logic [WIDTH-1:0] o_dat
);

  logic [WIDTH-1:0] r_pipe [DEPTH];

  always_ff @(posedge i_clk or negedge i_clr_n) begin
    if (!i_clr_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_dat;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_dat = r_pipe[DEPTH-1];

endmodule

// File: rtl/psdifir_mac_sequencer.sv
// Per-sample FIR control: commit sample, sweep taps, strobe MAC, latch result.
// Latency N+RD_LAT+MAC_LAT+2 clocks; strobes outside IDLE/DONE are dropped and flagged.
module psdifir_mac_sequencer #(
  parameter int ADDR_W  = psdifir_pkg::ADDR_W,
  parameter int NTAPS   = psdifir_pkg::NTAPS_DEF,
  parameter int RD_LAT  = psdifir_pkg::RD_LAT_DEF,
  parameter int MAC_LAT = psdifir_pkg::MAC_LAT_DEF
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_datain_ready,
  input  logic [ADDR_W:0]   i_ntaps_cfg,
  input  logic              i_overrun_clr,
  output logic              o_buf_we,
  output logic [ADDR_W-1:0] o_buf_waddr,
  output logic [ADDR_W-1:0] o_buf_raddr,
  output logic [ADDR_W-1:0] o_coef_addr,
  output logic              o_mac_en,
  output logic              o_mac_clear,
  output logic              o_out_latch,
  output logic              o_dataout_ready,
  output logic              o_busy,
  output logic              o_overrun
);

  import psdifir_pkg::*;

  // Drain covers the last accumulate edge plus the MAC output latency.
  localparam logic [7:0]      DRAIN_LAST = 8'(RD_LAT + MAC_LAT - 1);
  localparam logic [ADDR_W:0] NTAPS_L    = (ADDR_W+1)'(NTAPS);
  localparam logic [ADDR_W:0] ONE_L      = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W:0]   r_ntaps;
  logic [ADDR_W:0]   r_tap;
  logic [7:0]        r_drain;
  logic              r_issue;
  logic              r_first;
  logic              r_buf_we;
  logic [ADDR_W-1:0] r_buf_waddr;
  logic [ADDR_W-1:0] r_buf_raddr;
  logic [ADDR_W-1:0] r_coef_addr;
  logic              r_out_latch;
  logic              r_dout_rdy;
  logic              r_busy;
  logic              r_overrun;

  logic              w_accept_ok;
  logic              w_last_tap;
  logic [ADDR_W:0]   w_tap_nxt;
  logic [ADDR_W:0]   w_ntaps_lim;
  logic [1:0]        w_dl_out;

  assign w_accept_ok = (r_state == ST_IDLE) || (r_state == ST_DONE);
  assign w_last_tap  = (r_tap == (r_ntaps - ONE_L));
  assign w_tap_nxt   = r_tap + ONE_L;
  assign w_ntaps_lim = (i_ntaps_cfg == '0)     ? ONE_L   :
                       (i_ntaps_cfg > NTAPS_L) ? NTAPS_L : i_ntaps_cfg;

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state     <= ST_IDLE;
      r_wr_ptr    <= '0;
      r_ntaps     <= ONE_L;
      r_tap       <= '0;
      r_drain     <= '0;
      r_issue     <= 1'b0;
      r_first     <= 1'b0;
      r_buf_we    <= 1'b0;
      r_buf_waddr <= '0;
      r_buf_raddr <= '0;
      r_coef_addr <= '0;
      r_out_latch <= 1'b0;
      r_dout_rdy  <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_buf_we    <= 1'b0;
      r_out_latch <= 1'b0;
      r_dout_rdy  <= 1'b0;
      r_issue     <= 1'b0;
      r_first     <= 1'b0;

      if (i_datain_ready && !w_accept_ok) r_overrun <= 1'b1;
      else if (i_overrun_clr)             r_overrun <= 1'b0;

      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (i_datain_ready) begin
            r_state     <= ST_WRITE;
            r_busy      <= 1'b1;
            r_buf_we    <= 1'b1;
            r_buf_waddr <= r_wr_ptr;
            r_ntaps     <= w_ntaps_lim;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_WRITE: begin
          r_state     <= ST_RUN;
          r_tap       <= '0;
          r_issue     <= 1'b1;
          r_first     <= 1'b1;
          r_buf_raddr <= r_wr_ptr;
          r_coef_addr <= '0;
        end
        ST_RUN: begin
          if (w_last_tap) begin
            r_state     <= ST_DRAIN;
            r_drain     <= '0;
            r_wr_ptr    <= r_wr_ptr + 1'b1;
            r_buf_raddr <= '0;
            r_coef_addr <= '0;
          end else begin
            r_tap       <= w_tap_nxt;
            r_issue     <= 1'b1;
            r_buf_raddr <= r_wr_ptr - w_tap_nxt[ADDR_W-1:0];
            r_coef_addr <= w_tap_nxt[ADDR_W-1:0];
          end
        end
        ST_DRAIN: begin
          if (r_drain == DRAIN_LAST) begin
            r_state     <= ST_LATCH;
            r_out_latch <= 1'b1;
          end else begin
            r_drain <= r_drain + 1'b1;
          end
        end
        ST_LATCH: begin
          r_state    <= ST_DONE;
          r_dout_rdy <= 1'b1;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // first is only ever set alongside issue, so the delayed copy is already qualified.
  psdifir_delay_line #(
    .DEPTH (RD_LAT),
    .WIDTH (2)
  ) u_align (
    .i_clk   (i_clock),
    .i_clr_n (i_reset_n),
    .i_dat   ({r_first, r_issue}),
    .o_dat   (w_dl_out)
  );

  assign o_buf_we        = r_buf_we;
  assign o_buf_waddr     = r_buf_waddr;
  assign o_buf_raddr     = r_buf_raddr;
  assign o_coef_addr     = r_coef_addr;
  assign o_mac_en        = w_dl_out[0];
  assign o_mac_clear     = w_dl_out[1];
  assign o_out_latch     = r_out_latch;
  assign o_dataout_ready = r_dout_rdy;
  assign o_busy          = r_busy;
  assign o_overrun       = r_overrun;

endmodule

// File: tb/tb_psdifir_mac_sequencer.sv
// Directed bench for psdifir_mac_sequencer: timeline model of each accepted sample
// checked every cycle, plus literal expectations from hand-worked scenarios.
module tb_psdifir_mac_sequencer;

  localparam int AW    = 8;
  localparam int NT    = 256;
  localparam int RD    = 1;
  localparam int ML    = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          strobe = 1'b0;
  logic          clr = 1'b0;
  logic [AW:0]   cfg = '0;
  logic          buf_we, mac_en, mac_clear, out_latch, dout, busy, ovr;
  logic [AW-1:0] waddr, raddr, coef;

  always #5 clk = ~clk;

  psdifir_mac_sequencer #(
    .ADDR_W (AW), .NTAPS (NT), .RD_LAT (RD), .MAC_LAT (ML)
  ) u_dut (
    .i_clock         (clk),
    .i_reset_n       (rst_n),
    .i_datain_ready  (strobe),
    .i_ntaps_cfg     (cfg),
    .i_overrun_clr   (clr),
    .o_buf_we        (buf_we),
    .o_buf_waddr     (waddr),
    .o_buf_raddr     (raddr),
    .o_coef_addr     (coef),
    .o_mac_en        (mac_en),
    .o_mac_clear     (mac_clear),
    .o_out_latch     (out_latch),
    .o_dataout_ready (dout),
    .o_busy          (busy),
    .o_overrun       (ovr)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int n_dout = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Transaction model: each accepted sample owns a fixed timeline relative to its accept edge.
  int m_cyc = -1;
  int m_e0  = -1;
  int m_n   = 1;
  int m_wtx = 0;
  int m_wp  = 0;
  bit m_ovr = 1'b0;

  function automatic int clampn(input int c);
    if (c == 0) return 1;
    if (c > NT) return NT;
    return c;
  endfunction

  function automatic int total_len();
    return m_n + RD + ML + 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int dp;
    bit acc;
    if (!rst_n) begin
      m_cyc = -1; m_e0 = -1; m_wp = 0; m_ovr = 1'b0;
    end else begin
      dp  = m_cyc - m_e0;
      acc = (m_e0 < 0) || (dp >= total_len());
      if (strobe && acc) begin
        m_e0  = m_cyc + 1;
        m_n   = clampn(int'(cfg));
        m_wtx = m_wp;
        m_wp  = (m_wp + 1) % DEPTH;
      end
      if (strobe && !acc) m_ovr = 1'b1;
      else if (clr)       m_ovr = 1'b0;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    int d;
    bit act;
    act = (m_e0 >= 0);
    d   = act ? (m_cyc - m_e0) : -1;
    chk("buf_we",        buf_we,    act && d == 0);
    chk("mac_en",        mac_en,    act && d >= 1 + RD && d <= m_n + RD);
    chk("mac_clear",     mac_clear, act && d == 1 + RD);
    chk("out_latch",     out_latch, act && d == m_n + RD + ML + 1);
    chk("dataout_ready", dout,      act && d == total_len());
    chk("busy",          busy,      act && d >= 0 && d <= total_len());
    chk("overrun",       ovr,       m_ovr);
    if (act && d == 0) chk("buf_waddr", waddr, m_wtx);
    if (act && d >= 1 && d <= m_n) begin
      chk("buf_raddr", raddr, ((m_wtx - (d - 1)) % DEPTH + DEPTH) % DEPTH);
      chk("coef_addr", coef, d - 1);
    end
    if (dout) n_dout++;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_dr(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!dout && n < 2000);
    chk("dataout_ready_seen", dout, 1);
  endtask

  initial begin
    int n;
    int d0;

    repeat (4) @(posedge clk);
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_we", buf_we, 0);
    chk("rst_mac_en", mac_en, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovr", ovr, 0);
    chk("rst_raddr", raddr, 0);
    rst_n = 1'b1;
    tick(); tick();

    // N=4 first sample: write at 0, taps read 0,255,254,253, result 9 edges later
    cfg = 9'd4; strobe = 1'b1; d0 = n_dout;
    tick(); strobe = 1'b0;
    chk("t1_we", buf_we, 1);
    chk("t1_waddr", waddr, 0);
    tick(); chk("t1_raddr0", raddr, 0);   chk("t1_coef0", coef, 0); chk("t1_en_e1", mac_en, 0);
    tick(); chk("t1_raddr1", raddr, 255); chk("t1_coef1", coef, 1); chk("t1_clr_e2", mac_clear, 1);
    tick(); chk("t1_raddr2", raddr, 254); chk("t1_coef2", coef, 2); chk("t1_clr_e3", mac_clear, 0);
    tick(); chk("t1_raddr3", raddr, 253); chk("t1_coef3", coef, 3); chk("t1_en_e4", mac_en, 1);
    wait_dr(n);
    chk("t1_latency", 4 + n, 9);
    tick(); chk("t1_dout_width", dout, 0);
    chk("t1_pulses", n_dout - d0, 1);

    // dropped strobe three edges after an accepted one
    tick(); d0 = n_dout;
    strobe = 1'b1; tick(); strobe = 1'b0;
    tick(); tick();
    strobe = 1'b1; tick(); strobe = 1'b0;
    chk("ovr_set", ovr, 1);
    wait_dr(n); tick(); tick();
    chk("ovr_pulses", n_dout - d0, 1);
    clr = 1'b1; tick(); clr = 1'b0;
    chk("ovr_cleared", ovr, 0);

    // set and clear together: set wins
    strobe = 1'b1; tick(); strobe = 1'b0;
    tick();
    strobe = 1'b1; clr = 1'b1; tick(); strobe = 1'b0; clr = 1'b0;
    chk("ovr_set_wins", ovr, 1);
    wait_dr(n); tick();

    // ntaps 0 behaves as 1; strobe in DONE chains straight into WRITE; 300 clamps to 256
    cfg = 9'd0; strobe = 1'b1; tick(); strobe = 1'b0;
    wait_dr(n);
    chk("n0_latency", n, 6);
    cfg = 9'd300; strobe = 1'b1; tick(); strobe = 1'b0;
    chk("b2b_we", buf_we, 1);
    chk("b2b_waddr", waddr, 4);
    wait_dr(n);
    chk("clamp_latency", n, 261);
    tick();

    // reset during RUN discards the sample
    cfg = 9'd8; strobe = 1'b1; tick(); strobe = 1'b0;
    tick(); tick();
    rst_n = 1'b0; #1;
    chk("mr_busy", busy, 0);
    chk("mr_mac_en", mac_en, 0);
    chk("mr_coef", coef, 0);
    chk("mr_ovr", ovr, 0);
    d0 = n_dout;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("mr_no_dout", n_dout - d0, 0);
    cfg = 9'd1; strobe = 1'b1; tick(); strobe = 1'b0;
    chk("mr_waddr", waddr, 0);
    wait_dr(n);

    // write pointer wrap with N=1, every strobe issued in DONE
    for (int i = 1; i <= DEPTH; i++) begin
      strobe = 1'b1; tick(); strobe = 1'b0;
      chk("wrap_we", buf_we, 1);
      if (i == DEPTH - 1) chk("wrap_waddr_last", waddr, DEPTH - 1);
      if (i == DEPTH) begin
        chk("wrap_waddr0", waddr, 0);
        tick();
        chk("wrap_raddr0", raddr, 0);
      end
      wait_dr(n);
    end
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
